// File: rtl/bnn_pkg.sv
// bnn_pkg: function codes and controller states for the BNN dot-product CFU.
package bnn_pkg;

  typedef enum logic [2:0] {
    BNN_DOT = 3'd0,
    BNN_MAC = 3'd1,
    BNN_CLR = 3'd2,
    BNN_RD  = 3'd3
  } bnn_func_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } bnn_state_e;

endpackage

// File: rtl/cfu_pkg.sv
// cfu_pkg: shared CFU-L2 definitions.
// Provides the response status width and codes, plus a helper that
// validates the CFU-L2 parameter set a unit was elaborated with.
package cfu_pkg;

  localparam int unsigned CFU_STATUS_W = 3;

  localparam logic [CFU_STATUS_W-1:0] CFU_OK       = 3'd0;
  localparam logic [CFU_STATUS_W-1:0] CFU_ERROR_OP = 3'd1;

  // Only version 0, a single CFU and 32/64-bit data are supported.
  function automatic bit check_cfu_l2_params(input int unsigned version,
                                             input int unsigned n_cfus,
                                             input int unsigned cfu_id_w,
                                             input int unsigned data_w);
    return (version == 0) && (n_cfus == 1) && (cfu_id_w <= 32) &&
           ((data_w == 32) || (data_w == 64));
  endfunction

endpackage

// File: rtl/bnn_seq_cfu_if.sv
// bnn_seq_cfu_if: CFU-L2 request/response bundle.
//   master : CPU side (drives req_*, resp_ready)
//   slave  : CFU side (drives req_ready, resp_*)
// A zero-width CFU id is carried as a single ignored bit.
interface bnn_seq_cfu_if #(
  parameter int unsigned CFU_ID_W  = 0,
  parameter int unsigned FUNC_ID_W = 3,
  parameter int unsigned DATA_W    = 32
);
  localparam int unsigned ID_W = (CFU_ID_W > 0) ? CFU_ID_W : 1;

  logic                              req_valid;
  logic                              req_ready;
  logic [ID_W-1:0]                   req_cfu;
  logic [FUNC_ID_W-1:0]              req_func;
  logic [DATA_W-1:0]                 req_data0;
  logic [DATA_W-1:0]                 req_data1;
  logic                              resp_valid;
  logic                              resp_ready;
  logic [cfu_pkg::CFU_STATUS_W-1:0]  resp_status;
  logic [DATA_W-1:0]                 resp_data;

  modport master (
    output req_valid, req_cfu, req_func, req_data0, req_data1, resp_ready,
    input  req_ready, resp_valid, resp_status, resp_data
  );

  modport slave (
    input  req_valid, req_cfu, req_func, req_data0, req_data1, resp_ready,
    output req_ready, resp_valid, resp_status, resp_data
  );

endinterface

// File: rtl/bnn_slice_pop.sv
// bnn_slice_pop: combinational popcount of one SLICE_W-bit slice.
//   i_bits  : slice to count
//   o_count : number of set bits, $clog2(SLICE_W+1) wide
module bnn_slice_pop #(
  parameter  int unsigned SLICE_W = 8,
  localparam int unsigned POP_W   = $clog2(SLICE_W + 1)
) (
  input  logic [SLICE_W-1:0] i_bits,
  output logic [POP_W-1:0]   o_count
);

  always_comb begin
    o_count = '0;
    for (int unsigned i = 0; i < SLICE_W; i++) begin
      o_count = o_count + POP_W'(i_bits[i]);
    end
  end

endmodule

// File: rtl/bnn_seq_cfu.sv
// bnn_seq_cfu: serialized BNN dot-product unit behind a CFU-L2 port.
// XNORs the two operands, then counts the result one SLICE_W slice per
// cycle through a single shared popcount. DOT returns the count, MAC adds
// it to a persistent accumulator, CLR returns and clears the accumulator,
// RD returns it. Other function ids answer CFU_ERROR_OP.
//   clk, rst : clock, synchronous active-high reset
//   clk_en   : when low, every register holds
//   bus      : CFU request/response handshake (slave side)
module bnn_seq_cfu
  import cfu_pkg::*;
  import bnn_pkg::*;
#(
  parameter int unsigned CFU_VERSION   = 0,
  parameter int unsigned CFU_N_CFUS    = 1,
  parameter int unsigned CFU_CFU_ID_W  = 0,
  parameter int unsigned CFU_FUNC_ID_W = 3,
  parameter int unsigned CFU_DATA_W    = 32,
  parameter int unsigned SLICE_W       = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  bnn_seq_cfu_if.slave bus
);

  localparam int unsigned N_SLICE = CFU_DATA_W / SLICE_W;
  localparam int unsigned PSUM_W  = $clog2(CFU_DATA_W + 1);
  localparam int unsigned POP_W   = $clog2(SLICE_W + 1);
  localparam int unsigned K_W     = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;

  if (!check_cfu_l2_params(CFU_VERSION, CFU_N_CFUS, CFU_CFU_ID_W, CFU_DATA_W)) begin : g_bad_cfu
    $error("bnn_seq_cfu: unsupported CFU-L2 parameters");
  end
  if ((CFU_FUNC_ID_W == 0) || (CFU_FUNC_ID_W > 32)) begin : g_bad_func_w
    $error("bnn_seq_cfu: CFU_FUNC_ID_W must be 1..32");
  end
  if ((SLICE_W == 0) || ((CFU_DATA_W % SLICE_W) != 0)) begin : g_bad_slice
    $error("bnn_seq_cfu: SLICE_W must divide CFU_DATA_W");
  end

  bnn_state_e                r_state;
  logic [CFU_DATA_W-1:0]     r_x;
  logic [K_W-1:0]            r_k;
  logic [PSUM_W-1:0]         r_psum;
  logic                      r_is_mac;
  logic [CFU_DATA_W-1:0]     r_acc;
  logic                      r_resp_valid;
  logic [CFU_DATA_W-1:0]     r_resp_data;
  logic [CFU_STATUS_W-1:0]   r_resp_status;

  logic [POP_W-1:0]          w_pop;
  logic [PSUM_W-1:0]         w_psum_next;
  logic [CFU_DATA_W-1:0]     w_psum_ext;
  logic [CFU_DATA_W-1:0]     w_mac_sum;
  logic                      w_last;
  logic [31:0]               w_func;
  logic                      w_is_dot;
  logic                      w_is_mac;
  logic                      w_is_clr;
  logic                      w_is_rd;
  logic                      w_unused_cfu;

  // r_x is shifted right each BUSY cycle so the popcount always sees bits [SLICE_W-1:0].
  bnn_slice_pop #(
    .SLICE_W (SLICE_W)
  ) u_slice_pop (
    .i_bits  (r_x[SLICE_W-1:0]),
    .o_count (w_pop)
  );

  assign w_psum_next  = r_psum + PSUM_W'(w_pop);
  assign w_psum_ext   = CFU_DATA_W'(w_psum_next);
  assign w_mac_sum    = r_acc + w_psum_ext;
  assign w_last       = (r_k == K_W'(N_SLICE - 1));

  assign w_func       = 32'(bus.req_func);
  assign w_is_dot     = (w_func == 32'(BNN_DOT));
  assign w_is_mac     = (w_func == 32'(BNN_MAC));
  assign w_is_clr     = (w_func == 32'(BNN_CLR));
  assign w_is_rd      = (w_func == 32'(BNN_RD));
  assign w_unused_cfu = ^bus.req_cfu;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_x           <= '0;
      r_k           <= '0;
      r_psum        <= '0;
      r_is_mac      <= 1'b0;
      r_acc         <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_data   <= '0;
      r_resp_status <= CFU_OK;
    end else if (clk_en) begin
      unique case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            if (w_is_dot || w_is_mac) begin
              r_x      <= bus.req_data0 ~^ bus.req_data1;
              r_is_mac <= w_is_mac;
              r_psum   <= '0;
              r_k      <= '0;
              r_state  <= BUSY;
            end else begin
              r_resp_valid  <= 1'b1;
              r_state       <= RESP;
              r_resp_status <= CFU_OK;
              if (w_is_clr) begin
                r_resp_data <= r_acc;
                r_acc       <= '0;
              end else if (w_is_rd) begin
                r_resp_data <= r_acc;
              end else begin
                r_resp_data   <= '0;
                r_resp_status <= CFU_ERROR_OP;
              end
            end
          end
        end
        BUSY: begin
          r_psum <= w_psum_next;
          r_k    <= r_k + K_W'(1);
          r_x    <= r_x >> SLICE_W;
          if (w_last) begin
            r_state       <= RESP;
            r_resp_valid  <= 1'b1;
            r_resp_status <= CFU_OK;
            if (r_is_mac) begin
              r_acc       <= w_mac_sum;
              r_resp_data <= w_mac_sum;
            end else begin
              r_resp_data <= w_psum_ext;
            end
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (r_state == IDLE);
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_data   = r_resp_data;
  assign bus.resp_status = r_resp_status;

endmodule

// File: tb/tb_bnn_seq_cfu.sv
module tb_bnn_seq_cfu;
  import cfu_pkg::*;
  import bnn_pkg::*;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SLICE_W = 8;
  localparam int          N_SLICE = DATA_W / SLICE_W;

  logic clk;
  logic rst;
  logic clk_en;

  int n_tests;
  int n_fail;
  logic [31:0] m_acc;

  bnn_seq_cfu_if #(.CFU_ID_W(0), .FUNC_ID_W(3), .DATA_W(DATA_W)) bus_if ();

  bnn_seq_cfu #(
    .CFU_VERSION   (0),
    .CFU_N_CFUS    (1),
    .CFU_CFU_ID_W  (0),
    .CFU_FUNC_ID_W (3),
    .CFU_DATA_W    (DATA_W),
    .SLICE_W       (SLICE_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_d;
    logic [2:0]  exp_st;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: popcount of the XNOR, accumulator as a plain 32-bit integer.
  function automatic void model_op(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] d,
                                   output logic [2:0] st, output int lat);
    logic [31:0] pc;
    pc  = 32'($countones(~(a ^ b)));
    st  = CFU_OK;
    lat = 0;
    d   = '0;
    case (f)
      3'd0: begin d = pc; lat = N_SLICE; end
      3'd1: begin m_acc = m_acc + pc; d = m_acc; lat = N_SLICE; end
      3'd2: begin d = m_acc; m_acc = '0; end
      3'd3: d = m_acc;
      default: st = CFU_ERROR_OP;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_acc = '0;
  endtask

  // One full transaction with resp_ready held high.
  task automatic exec(input string tag, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp_d,
                      input logic [2:0] exp_st, input int exp_lat);
    int guard;
    int lat;
    bus_if.req_func   = f;
    bus_if.req_data0  = a;
    bus_if.req_data1  = b;
    bus_if.req_valid  = 1'b1;
    bus_if.resp_ready = 1'b1;
    guard = 0;
    while (!bus_if.req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    lat = 0;
    while (!bus_if.resp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    check({tag, ".data"}, 64'(bus_if.resp_data), 64'(exp_d));
    check({tag, ".status"}, 64'(bus_if.resp_status), 64'(exp_st));
    @(posedge clk); #1;
    check({tag, ".ready_after"}, 64'({bus_if.req_ready, bus_if.resp_valid}), 64'(2'b10));
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] held;
    logic [2:0]  st;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    int          elat;
    logic        seen;

    n_tests = 0;
    n_fail  = 0;
    m_acc   = '0;
    rst     = 1'b1;
    clk_en  = 1'b1;
    bus_if.req_valid  = 1'b0;
    bus_if.req_cfu    = '0;
    bus_if.req_func   = '0;
    bus_if.req_data0  = '0;
    bus_if.req_data1  = '0;
    bus_if.resp_ready = 1'b0;

    vecs[0] = '{BNN_DOT, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'd16, CFU_OK,       N_SLICE};
    vecs[1] = '{BNN_CLR, 32'h0,         32'h0,         32'd0,  CFU_OK,       0};
    vecs[2] = '{BNN_MAC, 32'h0000_00FF, 32'h0000_00FF, 32'd32, CFU_OK,       N_SLICE};
    vecs[3] = '{BNN_MAC, 32'h0,         32'hFFFF_FFFF, 32'd32, CFU_OK,       N_SLICE};
    vecs[4] = '{BNN_RD,  32'h0,         32'h0,         32'd32, CFU_OK,       0};
    vecs[5] = '{BNN_CLR, 32'h0,         32'h0,         32'd32, CFU_OK,       0};
    vecs[6] = '{BNN_RD,  32'h0,         32'h0,         32'd0,  CFU_OK,       0};
    vecs[7] = '{3'd5,    32'hDEAD_BEEF, 32'h1234_5678, 32'd0,  CFU_ERROR_OP, 0};
    vecs[8] = '{BNN_RD,  32'h0,         32'h0,         32'd0,  CFU_OK,       0};

    // Reset state
    do_reset();
    check("reset.req_ready", 64'(bus_if.req_ready), 64'd1);
    check("reset.resp_valid", 64'(bus_if.resp_valid), 64'd0);
    check("reset.resp_data", 64'(bus_if.resp_data), 64'd0);
    check("reset.resp_status", 64'(bus_if.resp_status), 64'(CFU_OK));

    // Directed table
    for (int i = 0; i < 9; i++) begin
      exec($sformatf("vec%0d", i), vecs[i].func, vecs[i].a, vecs[i].b,
           vecs[i].exp_d, vecs[i].exp_st, vecs[i].exp_lat);
    end

    // Accumulator wraps modulo 2^32
    do_reset();
    force dut.r_acc = 32'hFFFF_FFF0;
    exec("wrap", BNN_MAC, 32'h0, 32'h0, 32'h0000_0010, CFU_OK, N_SLICE);
    release dut.r_acc;
    do_reset();

    // clk_en low inside BUSY plus a long resp_ready stall
    a = 32'h1234_5678;
    b = 32'hFFFF_0000;
    model_op(BNN_DOT, a, b, d, st, elat);
    bus_if.req_func   = BNN_DOT;
    bus_if.req_data0  = a;
    bus_if.req_data1  = b;
    bus_if.req_valid  = 1'b1;
    bus_if.resp_ready = 1'b0;
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    check("stall.busy_ready", 64'(bus_if.req_ready), 64'd0);
    lat = 0;
    @(posedge clk); #1; lat++;
    clk_en = 1'b0;
    repeat (3) begin @(posedge clk); #1; lat++; end
    clk_en = 1'b1;
    while (!bus_if.resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("stall.lat", 64'(lat), 64'(elat + 3));
    check("stall.data", 64'(bus_if.resp_data), 64'(d));
    held = bus_if.resp_data;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("stall.hold%0d", i),
            64'({bus_if.resp_valid, bus_if.req_ready, bus_if.resp_data}),
            64'({1'b1, 1'b0, held}));
    end
    // Consumer ready while clk_en low: handshake must not complete
    clk_en = 1'b0;
    bus_if.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("stall.en_low_hold", 64'({bus_if.resp_valid, bus_if.req_ready}), 64'(2'b10));
    clk_en = 1'b1;
    @(posedge clk); #1;
    check("stall.consumed", 64'({bus_if.resp_valid, bus_if.req_ready}), 64'(2'b01));

    // Reset in the second BUSY cycle of a MAC drops it and clears acc
    model_op(BNN_MAC, 32'h0000_00FF, 32'h0000_00FF, d, st, elat);
    exec("pre_rst_mac", BNN_MAC, 32'h0000_00FF, 32'h0000_00FF, d, st, elat);
    bus_if.req_func   = BNN_MAC;
    bus_if.req_valid  = 1'b1;
    bus_if.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_acc = '0;
    seen = 1'b0;
    repeat (8) begin
      if (bus_if.resp_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("rst_busy.no_resp", 64'(seen), 64'd0);
    check("rst_busy.ready", 64'(bus_if.req_ready), 64'd1);
    exec("rst_busy.rd", BNN_RD, 32'h0, 32'h0, 32'd0, CFU_OK, 0);

    // Randomized ops against the reference model
    do_reset();
    for (int i = 0; i < 60; i++) begin
      int r;
      r = int'($urandom_range(0, 11));
      f = (r < 4) ? BNN_MAC : 3'(r - 4);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a ^ (32'h1 << $urandom_range(0, 31)) : $urandom;
      model_op(f, a, b, d, st, elat);
      exec($sformatf("rand%0d", i), f, a, b, d, st, elat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
